// File: rtl/sha256_padder.sv
// SHA-256 message padder: byte stream in, padded byte stream out
// (message, 0x80, zero fill, big-endian bit length) in 64-byte blocks.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_byte,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       busy
);
  localparam int NB = LEN_W / 8;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [5:0] LEN_POS = 6'(64 - NB);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_PAD, S_ZERO, S_LEN} state_t;

  state_t            r_state, w_nxt;
  logic [5:0]        r_byte_cnt;
  logic [LEN_W-1:0]  r_bit_len;
  logic [IW-1:0]     r_len_idx;
  logic [7:0]        r_out_byte;
  logic              r_out_valid, r_out_last;

  logic              w_slot, w_accept, w_ld, w_ld_last, w_fill_done;
  logic [7:0]        w_ld_byte;
  logic [LEN_W-1:0]  w_len_sh;

  assign w_slot      = !r_out_valid || out_ready;
  assign in_ready    = ((r_state == S_IDLE) || (r_state == S_DATA)) && w_slot;
  assign w_accept    = in_valid && in_ready;
  assign w_fill_done = ((r_byte_cnt + 6'd1) == LEN_POS);
  assign w_len_sh    = r_bit_len >> {r_len_idx, 3'b000};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE, S_DATA: if (w_accept) w_nxt = in_last ? S_PAD : S_DATA;
      S_PAD, S_ZERO:  if (w_slot) w_nxt = w_fill_done ? S_LEN : S_ZERO;
      S_LEN:          if (r_out_valid && out_ready && r_out_last) w_nxt = S_IDLE;
      default:        w_nxt = S_IDLE;
    endcase
  end

  // Output-slot load: in LEN, stop loading once the final length byte is held.
  always_comb begin
    w_ld      = 1'b0;
    w_ld_byte = 8'h00;
    w_ld_last = 1'b0;
    case (r_state)
      S_IDLE, S_DATA: begin w_ld = w_accept; w_ld_byte = in_byte; end
      S_PAD:          begin w_ld = w_slot;   w_ld_byte = 8'h80;   end
      S_ZERO:         begin w_ld = w_slot;   w_ld_byte = 8'h00;   end
      S_LEN: begin
        w_ld      = w_slot && !r_out_last;
        w_ld_byte = w_len_sh[7:0];
        w_ld_last = (r_len_idx == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_ld) begin
      r_out_byte  <= w_ld_byte;
      r_out_valid <= 1'b1;
      r_out_last  <= w_ld_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= 6'd0;
      r_bit_len  <= '0;
      r_len_idx  <= IW'(NB - 1);
    end else begin
      if (w_ld) r_byte_cnt <= r_byte_cnt + 6'd1;
      if (w_accept)
        r_bit_len <= r_bit_len + LEN_W'(8);
      else if (r_state != S_IDLE && w_nxt == S_IDLE)
        r_bit_len <= '0;
      if (r_state != S_LEN)  r_len_idx <= IW'(NB - 1);
      else if (w_ld)         r_len_idx <= r_len_idx - 1'b1;
    end
  end

  assign out_byte  = r_out_byte;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: reset, padding boundaries, stalls, mid-message reset.
module tb_sha256_padder;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_byte;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_byte;
  logic       out_valid, out_ready, out_last, busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] msg [0:127];
  logic [7:0] got [$];
  int         lastn, lastpos, stall_viol, bubbles, busy_viol;
  bit         timeout;

  sha256_padder #(.LEN_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_byte(out_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive an n-byte message from msg[], collect the output stream until the
  // out_last transfer; in_valid stays high after the message to probe ignoring.
  task automatic run(input int n, input bit rnd);
    int idx = 0;
    int cyc = 0;
    bit done = 0, started = 0, prev_stall = 0;
    logic [7:0] pb;
    logic pl;
    got.delete();
    lastn = 0; lastpos = -1; stall_viol = 0; bubbles = 0; busy_viol = 0; timeout = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_valid  = 1'b1;
      in_byte   = (idx < n) ? msg[idx] : 8'hEE;
      in_last   = (idx == n - 1);
      #1;
      if (prev_stall && (out_byte !== pb || out_last !== pl || out_valid !== 1'b1)) stall_viol++;
      if (out_valid && !out_ready && in_ready) stall_viol++;
      if (started && !out_valid) bubbles++;
      if (started && !busy) busy_viol++;
      prev_stall = out_valid && !out_ready;
      pb = out_byte; pl = out_last;
      if (in_valid && in_ready) begin idx++; started = 1; end
      if (out_valid && out_ready) begin
        got.push_back(out_byte);
        if (out_last) begin lastn++; lastpos = got.size() - 1; done = 1; end
      end
      cyc++;
    end
    if (!done) timeout = 1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
  endtask

  task automatic fill_msg();
    for (int i = 0; i < 128; i++) msg[i] = 8'(i + 1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    #3;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_byte !== 8'h00) begin failures++; $display("FAIL reset_out_byte got=%h exp=00", out_byte); end
    checks++; if (out_last !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_last_busy got=%b%b exp=00", out_last, busy); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic check_abc(input string tag);
    logic [7:0] e, g;
    checks++; if (timeout || got.size() != 64) begin failures++; $display("FAIL %s_len got=%0d exp=64 timeout=%0d", tag, got.size(), timeout); end
    for (int i = 0; i < 64; i++) begin
      e = (i < 3) ? 8'(8'h61 + i) : (i == 3) ? 8'h80 : (i == 63) ? 8'h18 : 8'h00;
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL %s_byte[%0d] got=%h exp=%h", tag, i, g, e); end
    end
    checks++; if (lastn != 1 || lastpos != 63) begin failures++; $display("FAIL %s_last got=pos%0d n%0d exp=pos63 n1", tag, lastpos, lastn); end
  endtask

  task automatic test_abc();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run(3, 1'b0);
    check_abc("abc");
    checks++; if (bubbles != 0) begin failures++; $display("FAIL abc_bubbles got=%0d exp=0", bubbles); end
    checks++; if (busy_viol != 0) begin failures++; $display("FAIL abc_busy_mid got=%0d exp=0", busy_viol); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL abc_busy_end got=%b%b exp=00", busy, out_valid); end
  endtask

  task automatic test_len55();
    logic [7:0] e, g;
    fill_msg();
    run(55, 1'b0);
    checks++; if (timeout || got.size() != 64) begin failures++; $display("FAIL m55_len got=%0d exp=64", got.size()); end
    for (int i = 0; i < 64; i++) begin
      e = (i < 55) ? 8'(i + 1) : (i == 55) ? 8'h80 : (i == 62) ? 8'h01 : (i == 63) ? 8'hB8 : 8'h00;
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL m55_byte[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_len56();
    logic [7:0] e, g;
    fill_msg();
    run(56, 1'b0);
    checks++; if (timeout || got.size() != 128) begin failures++; $display("FAIL m56_len got=%0d exp=128", got.size()); end
    for (int i = 0; i < 128; i++) begin
      e = (i < 56) ? 8'(i + 1) : (i == 56) ? 8'h80 : (i == 126) ? 8'h01 : (i == 127) ? 8'hC0 : 8'h00;
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL m56_byte[%0d] got=%h exp=%h", i, g, e); end
    end
    checks++; if (lastn != 1 || lastpos != 127) begin failures++; $display("FAIL m56_last got=pos%0d n%0d exp=pos127 n1", lastpos, lastn); end
    checks++; if (bubbles != 0) begin failures++; $display("FAIL m56_bubbles got=%0d exp=0", bubbles); end
  endtask

  task automatic test_len64();
    logic [7:0] e, g;
    fill_msg();
    run(64, 1'b0);
    checks++; if (timeout || got.size() != 128) begin failures++; $display("FAIL m64_len got=%0d exp=128", got.size()); end
    for (int i = 0; i < 128; i++) begin
      e = (i < 64) ? 8'(i + 1) : (i == 64) ? 8'h80 : (i == 126) ? 8'h02 : 8'h00;
      g = (i < got.size()) ? got[i] : 8'hxx;
      checks++; if (g !== e) begin failures++; $display("FAIL m64_byte[%0d] got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_stall();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run(3, 1'b1);
    check_abc("stall");
    checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_hold got=%0d violations exp=0", stall_viol); end
  endtask

  task automatic test_reset_mid();
    fill_msg();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_byte = msg[i]; in_last = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got=%b%b exp=11", busy, out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_byte !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL mid_reset got=v%b b%h l%b busy%b exp=v0 b00 l0 busy0", out_valid, out_byte, out_last, busy); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    run(3, 1'b0);
    check_abc("mid");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_len55();
    test_len56();
    test_len64();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sha256_padder.md
SHA256_PADDER -- requirements
Module: sha256_padder

Interface
REQ-001 SHALL have parameter LEN_W, default 64, the width of the message bit-length counter and of the appended length field (64 per FIPS 180-4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_byte, input, 8 bits: message byte from the host byte stream.
REQ-005 SHALL have port in_valid, input, 1 bit: in_byte is valid.
REQ-006 SHALL have port in_last, input, 1 bit: qualifies in_valid; the byte is the final message byte. Messages are at least 1 byte.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts in_byte this cycle.
REQ-008 SHALL have port out_byte, output, 8 bits: padded-stream byte to the byte-to-word packer stage.
REQ-009 SHALL have port out_valid, output, 1 bit: out_byte is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts out_byte this cycle.
REQ-011 SHALL have port out_last, output, 1 bit: out_byte is the final byte of the final 64-byte block.
REQ-012 SHALL have port busy, output, 1 bit: a message is in progress (state other than IDLE).

Function
REQ-013 Transfer rule: a byte moves when valid and ready are both 1 on a rising edge; while out_valid=1 and out_ready=0, out_byte and out_last SHALL hold stable.
REQ-014 in_ready SHALL equal (state is IDLE or DATA) AND (out_valid=0 OR out_ready=1), combinationally.
REQ-015 An accepted input byte SHALL appear on out_byte with out_valid=1 on the next cycle (latency 1); passthrough is unmodified.
REQ-016 States: IDLE, DATA, PAD, ZERO, LEN.
REQ-017 IDLE/DATA: on accept with in_last=0 -> DATA; with in_last=1 -> PAD.
REQ-018 PAD: emit 0x80 once (loaded when output register free) -> ZERO if byte_cnt after it is not 56, else -> LEN.
REQ-019 ZERO: emit 0x00 per output slot until byte_cnt = 56 (mod 64), then -> LEN; the count wraps through 63->0, so an extra block is produced when the 0x80 lands at position 56..63.
REQ-020 LEN: emit the LEN_W/8 bytes of bit_len, most-significant byte first; out_last=1 with the final length byte only; after its transfer -> IDLE.
REQ-021 byte_cnt SHALL be 6 bits, increment on every out_valid load, and wrap 63->0; the final length byte always occupies position 63.
REQ-022 bit_len SHALL increment by 8 per accepted input byte, modulo 2^LEN_W, and clear on return to IDLE.
REQ-023 No bubbles: with out_ready held 1, one output byte per cycle from first accept through out_last.
REQ-024 in_valid during PAD/ZERO/LEN SHALL be ignored (in_ready=0) and not counted.
REQ-025 busy SHALL be 1 from the cycle after the first accept until the cycle after the out_last transfer.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, byte_cnt=0, bit_len=0, out_byte=0x00, out_valid=0, out_last=0, busy=0, regardless of clk.
REQ-027 Reset mid-message SHALL discard the message; first accept after release starts a new message at byte_cnt=0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-029 "abc" (61 62 63, last on 63), out_ready=1 -> 64 bytes: 61 62 63 80, 52x00, 00 00 00 00 00 00 00 18; out_last on byte 63 only.
REQ-030 55-byte message -> exactly 64 bytes; 0x80 at position 55; length bytes 00..01 B8.
REQ-031 56-byte message -> 128 bytes; 0x80 at position 56; 63 zeros; length 00..01 C0; out_last on byte 127 only.
REQ-032 64-byte message -> 128 bytes; second block = 80, 55x00, 00..02 00.
REQ-033 Random out_ready deassertion during "abc" -> out_byte/out_last stable while stalled; byte sequence identical to REQ-029; in_ready=0 whenever out_valid=1 and out_ready=0.
REQ-034 rst_n pulsed low after 10 bytes of a message -> outputs at reset values within the same cycle; subsequent "abc" yields REQ-029 output exactly.
